// File: rtl/formula_isqrt_sum_fsm_if.sv
// rtl/formula_isqrt_sum_fsm_if.sv - harness and isqrt-lane signal bundle for formula_isqrt_sum_fsm
// Purpose: groups the argument/result handshake and the per-lane isqrt bus.
// Signals:
//   arg_vld, arg_rdy, arg   argument vector handshake (arg[i] = bits [32*i+31:32*i])
//   res_vld, res            one-cycle result strobe and held 32-bit sum
//   isqrt_x_vld, isqrt_x    per-lane request valid and 32-bit operand
//   isqrt_y_vld, isqrt_y    per-lane result valid and 16-bit root
// Modports: slave = the summing FSM, master = the side that drives arguments and isqrt results.
interface formula_isqrt_sum_fsm_if #(
  parameter int N_ARGS  = 3,
  parameter int N_ISQRT = 2
);
  logic                    arg_vld;
  logic                    arg_rdy;
  logic [N_ARGS*32-1:0]    arg;
  logic                    res_vld;
  logic [31:0]             res;
  logic [N_ISQRT-1:0]      isqrt_x_vld;
  logic [N_ISQRT*32-1:0]   isqrt_x;
  logic [N_ISQRT-1:0]      isqrt_y_vld;
  logic [N_ISQRT*16-1:0]   isqrt_y;

  modport slave (
    input  arg_vld, arg, isqrt_y_vld, isqrt_y,
    output arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
  );

  modport master (
    output arg_vld, arg, isqrt_y_vld, isqrt_y,
    input  arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
  );
endinterface

// File: rtl/formula_isqrt_sum_fsm.sv
// rtl/formula_isqrt_sum_fsm.sv - sums isqrt of N_ARGS arguments over N_ISQRT time-shared isqrt lanes
// Purpose: latches an argument vector, dispatches it in rounds of up to N_ISQRT lanes,
//   collects lane results in any order and emits their 32-bit sum with a one-cycle strobe.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (release synchronised internally)
//   bus    formula_isqrt_sum_fsm_if.slave: arg_vld/arg_rdy/arg in, res_vld/res out,
//          isqrt_x_vld/isqrt_x out per lane, isqrt_y_vld/isqrt_y in per lane
module formula_isqrt_sum_fsm #(
  parameter int N_ARGS  = 3,
  parameter int N_ISQRT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  formula_isqrt_sum_fsm_if.slave bus
);
  localparam int ROUNDS = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
  localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic [RW-1:0]         round_q, round_d;
  logic [N_ISQRT-1:0]    done_q, done_d;
  logic [31:0]           acc_q, acc_d;
  logic [31:0]           res_q, res_d;
  logic [N_ARGS*32-1:0]  args_q, args_d;
  logic [N_ISQRT-1:0]    active;
  logic [N_ISQRT*32-1:0] x;
  logic [31:0]           sum;
  logic                  all_done;
  logic [1:0]            rst_sync_q;
  logic                  rst_int_n;

  // Reset asserts immediately but releases two edges later, so the FSM never
  // leaves reset on a clock edge that races the external deassertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Lane j of the current round carries argument round*N_ISQRT+j; lanes past
  // the last argument in the final round stay inactive.
  always_comb begin : lane_map
    int idx;
    active = '0;
    x      = '0;
    idx    = 0;
    for (int j = 0; j < N_ISQRT; j++) begin
      idx = int'(round_q) * N_ISQRT + j;
      if (idx < N_ARGS) begin
        active[j]       = 1'b1;
        x[j*32 +: 32]   = args_q[idx*32 +: 32];
      end
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    round_d  = round_q;
    done_d   = done_q;
    acc_d    = acc_q;
    res_d    = res_q;
    args_d   = args_q;
    sum      = acc_q;
    all_done = 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.arg_vld) begin
          args_d  = bus.arg;
          acc_d   = '0;
          round_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        done_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done_q gates repeats so a duplicate strobe is never added twice;
        // done_d lets the completing cycle count toward all_done.
        for (int j = 0; j < N_ISQRT; j++) begin
          if (active[j] && !done_q[j] && bus.isqrt_y_vld[j]) begin
            sum       = sum + {16'd0, bus.isqrt_y[j*16 +: 16]};
            done_d[j] = 1'b1;
          end
          if (active[j] && !done_d[j]) begin
            all_done = 1'b0;
          end
        end
        acc_d = sum;
        if (all_done) begin
          if (round_q == RW'(ROUNDS - 1)) begin
            // Result is loaded on entry to DONE so res is valid alongside res_vld.
            res_d   = sum;
            state_d = DONE;
          end else begin
            round_d = round_q + RW'(1);
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      round_q <= '0;
      done_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      args_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      args_q  <= args_d;
    end
  end

  assign bus.arg_rdy     = (state_q == IDLE);
  assign bus.res_vld     = (state_q == DONE);
  assign bus.res         = res_q;
  assign bus.isqrt_x_vld = (state_q == ISSUE) ? active : '0;
  assign bus.isqrt_x     = x;
endmodule

// File: tb/tb_formula_isqrt_sum_fsm.sv
// tb/tb_formula_isqrt_sum_fsm.sv - scoreboard bench for formula_isqrt_sum_fsm in three configurations
module tb_formula_isqrt_sum_fsm;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  formula_isqrt_sum_fsm_if #(.N_ARGS(3), .N_ISQRT(2)) ifa ();
  formula_isqrt_sum_fsm_if #(.N_ARGS(4), .N_ISQRT(4)) ifb ();
  formula_isqrt_sum_fsm_if #(.N_ARGS(1), .N_ISQRT(1)) ifc ();

  formula_isqrt_sum_fsm #(.N_ARGS(3), .N_ISQRT(2)) dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));
  formula_isqrt_sum_fsm #(.N_ARGS(4), .N_ISQRT(4)) dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb));
  formula_isqrt_sum_fsm #(.N_ARGS(1), .N_ISQRT(1)) dut_c (.clk(clk), .rst_n(rst_c), .bus(ifc));

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t sb_c[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at t=%0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [15:0] isqrt32(input logic [31:0] v);
    logic [31:0] r, t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (t * t <= v) r = t;
    end
    return r[15:0];
  endfunction

  // isqrt stand-in for config A: per-round, per-lane latency, optional duplicate
  // strobe and optional spurious strobe on an inactive lane.
  int          lat_a [2][2];
  bit          dup_a [2][2];
  bit          spur_a[2][2];
  int          cnt_a [2];
  bit          dupn_a[2];
  logic [15:0] val_a [2];
  int          rnd_a = 0;

  always @(negedge clk) begin
    logic [1:0]  yv;
    logic [31:0] yd;
    int          r;
    yv = '0;
    yd = '0;
    if (ifa.arg_rdy) rnd_a = 0;
    for (int j = 0; j < 2; j++) begin
      if (cnt_a[j] == 1) begin
        yv[j]            = 1'b1;
        yd[j*16 +: 16]   = val_a[j];
        cnt_a[j]         = dupn_a[j] ? 1 : 0;
        dupn_a[j]        = 1'b0;
      end else if (cnt_a[j] > 1) begin
        cnt_a[j]--;
      end
    end
    if (|ifa.isqrt_x_vld) begin
      r = (rnd_a > 1) ? 1 : rnd_a;
      chk("a_x_vld_mask", 32'(ifa.isqrt_x_vld), (r == 0) ? 32'd3 : 32'd1);
      chk("a_rdy_in_issue", 32'(ifa.arg_rdy), 32'd0);
      for (int j = 0; j < 2; j++) begin
        if (ifa.isqrt_x_vld[j]) begin
          chk("a_lane_idle_at_issue", cnt_a[j], 32'd0);
          val_a[j]  = isqrt32(ifa.isqrt_x[j*32 +: 32]);
          cnt_a[j]  = lat_a[r][j];
          dupn_a[j] = dup_a[r][j];
        end else if (spur_a[r][j]) begin
          val_a[j]  = 16'h00FF;
          cnt_a[j]  = lat_a[r][j];
          dupn_a[j] = 1'b0;
        end
      end
      rnd_a++;
    end
    ifa.isqrt_y_vld = yv;
    ifa.isqrt_y     = yd;
  end

  // Config B: four lanes, uniform latency 2.
  int          cnt_b[4];
  logic [15:0] val_b[4];

  always @(negedge clk) begin
    logic [3:0]  yv;
    logic [63:0] yd;
    yv = '0;
    yd = '0;
    for (int j = 0; j < 4; j++) begin
      if (cnt_b[j] == 1) begin
        yv[j]          = 1'b1;
        yd[j*16 +: 16] = val_b[j];
        cnt_b[j]       = 0;
      end else if (cnt_b[j] > 1) begin
        cnt_b[j]--;
      end
    end
    if (|ifb.isqrt_x_vld) begin
      chk("b_x_vld_mask", 32'(ifb.isqrt_x_vld), 32'hF);
      chk("b_rdy_in_issue", 32'(ifb.arg_rdy), 32'd0);
      for (int j = 0; j < 4; j++) begin
        if (ifb.isqrt_x_vld[j]) begin
          val_b[j] = isqrt32(ifb.isqrt_x[j*32 +: 32]);
          cnt_b[j] = 2;
        end
      end
    end
    ifb.isqrt_y_vld = yv;
    ifb.isqrt_y     = yd;
  end

  // Config C: single lane, latency 1, plus an injectable stray strobe.
  int          cnt_c = 0;
  logic [15:0] val_c;
  bit          inj_c = 1'b0;

  always @(negedge clk) begin
    logic        yv;
    logic [15:0] yd;
    yv = 1'b0;
    yd = '0;
    if (cnt_c == 1) begin
      yv    = 1'b1;
      yd    = val_c;
      cnt_c = 0;
    end else if (inj_c) begin
      yv = 1'b1;
      yd = 16'h1234;
    end
    if (ifc.isqrt_x_vld[0]) begin
      chk("c_rdy_in_issue", 32'(ifc.arg_rdy), 32'd0);
      val_c = isqrt32(ifc.isqrt_x);
      cnt_c = 1;
    end
    ifc.isqrt_y_vld = yv;
    ifc.isqrt_y     = yd;
  end

  // Result monitors: every res_vld pops one expectation; a strobe with nothing
  // expected (aborted op, stretched pulse) is itself a failure.
  always @(negedge clk) begin
    exp_t e;
    if (ifa.res_vld) begin
      if (sb_a.size() == 0) chk("a_res_vld_unexpected", 32'(ifa.res_vld), 32'd0);
      else begin
        e = sb_a.pop_front();
        chk("a_res", ifa.res, e.res);
        chk("a_latency", cyc - e.acc + 1, e.lat);
        chk("a_rdy_in_done", 32'(ifa.arg_rdy), 32'd0);
      end
    end
    if (ifb.res_vld) begin
      if (sb_b.size() == 0) chk("b_res_vld_unexpected", 32'(ifb.res_vld), 32'd0);
      else begin
        e = sb_b.pop_front();
        chk("b_res", ifb.res, e.res);
        chk("b_latency", cyc - e.acc + 1, e.lat);
      end
    end
    if (ifc.res_vld) begin
      if (sb_c.size() == 0) chk("c_res_vld_unexpected", 32'(ifc.res_vld), 32'd0);
      else begin
        e = sb_c.pop_front();
        chk("c_res", ifc.res, e.res);
        chk("c_latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic send_a(input logic [31:0] a0, a1, a2, input logic [31:0] exp, input int lat, input bit push);
    int t = 0;
    @(negedge clk);
    while (!ifa.arg_rdy && t < 300) begin @(negedge clk); t++; end
    chk("a_rdy_wait", 32'(ifa.arg_rdy), 32'd1);
    ifa.arg     = {a2, a1, a0};
    ifa.arg_vld = 1'b1;
    @(posedge clk); #1;
    ifa.arg_vld = 1'b0;
    if (push) sb_a.push_back('{res: exp, lat: lat, acc: cyc});
  endtask

  task automatic send_b(input logic [31:0] v, input logic [31:0] exp, input int lat);
    int t = 0;
    @(negedge clk);
    while (!ifb.arg_rdy && t < 300) begin @(negedge clk); t++; end
    chk("b_rdy_wait", 32'(ifb.arg_rdy), 32'd1);
    ifb.arg     = {v, v, v, v};
    ifb.arg_vld = 1'b1;
    @(posedge clk); #1;
    ifb.arg_vld = 1'b0;
    sb_b.push_back('{res: exp, lat: lat, acc: cyc});
  endtask

  task automatic send_c(input logic [31:0] v, input logic [31:0] exp, input int lat);
    int t = 0;
    @(negedge clk);
    while (!ifc.arg_rdy && t < 300) begin @(negedge clk); t++; end
    chk("c_rdy_wait", 32'(ifc.arg_rdy), 32'd1);
    ifc.arg     = v;
    ifc.arg_vld = 1'b1;
    @(posedge clk); #1;
    ifc.arg_vld = 1'b0;
    sb_c.push_back('{res: exp, lat: lat, acc: cyc});
  endtask

  task automatic idle_a();
    int t = 0;
    @(negedge clk);
    while ((sb_a.size() != 0 || !ifa.arg_rdy) && t < 300) begin @(negedge clk); t++; end
    chk("a_pending_results", sb_a.size(), 32'd0);
  endtask

  task automatic idle_b();
    int t = 0;
    @(negedge clk);
    while ((sb_b.size() != 0 || !ifb.arg_rdy) && t < 300) begin @(negedge clk); t++; end
    chk("b_pending_results", sb_b.size(), 32'd0);
  endtask

  task automatic idle_c();
    int t = 0;
    @(negedge clk);
    while ((sb_c.size() != 0 || !ifc.arg_rdy) && t < 300) begin @(negedge clk); t++; end
    chk("c_pending_results", sb_c.size(), 32'd0);
  endtask

  task automatic tables_a_default();
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 2; j++) begin
        lat_a[r][j]  = 4;
        dup_a[r][j]  = 1'b0;
        spur_a[r][j] = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    ifa.arg_vld = 1'b0; ifa.arg = '0;
    ifb.arg_vld = 1'b0; ifb.arg = '0;
    ifc.arg_vld = 1'b0; ifc.arg = '0;
    tables_a_default();
    repeat (2) @(negedge clk);
    chk("a_reset_rdy",   32'(ifa.arg_rdy),     32'd1);
    chk("a_reset_vld",   32'(ifa.res_vld),     32'd0);
    chk("a_reset_res",   ifa.res,              32'd0);
    chk("a_reset_x_vld", 32'(ifa.isqrt_x_vld), 32'd0);
    chk("b_reset_rdy",   32'(ifb.arg_rdy),     32'd1);
    chk("b_reset_res",   ifb.res,              32'd0);
    chk("c_reset_rdy",   32'(ifc.arg_rdy),     32'd1);
    chk("c_reset_res",   ifc.res,              32'd0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (3) @(negedge clk);

    // A: {16,25,81}, L=4, stray strobe on inactive lane 1 in round 1.
    lat_a[1][1]  = 2;
    spur_a[1][1] = 1'b1;
    send_a(16, 25, 81, 18, 11, 1'b1);
    idle_a();
    tables_a_default();

    // A: lane0 late (13), lane1 first (7) with a duplicate strobe.
    lat_a[0][0] = 13;
    lat_a[0][1] = 7;
    dup_a[0][1] = 1'b1;
    send_a(16, 25, 81, 18, 20, 1'b1);
    idle_a();
    tables_a_default();

    // A: busy arg_vld is dropped, then re-presented.
    send_a(16, 25, 81, 18, 11, 1'b1);
    repeat (3) @(negedge clk);
    chk("a_rdy_busy", 32'(ifa.arg_rdy), 32'd0);
    ifa.arg     = {32'd9, 32'd4, 32'd1};
    ifa.arg_vld = 1'b1;
    @(negedge clk);
    ifa.arg_vld = 1'b0;
    idle_a();
    send_a(1, 4, 9, 6, 11, 1'b1);
    idle_a();

    // A: reset during round 1 wait; stale lane result lands in IDLE.
    send_a(16, 25, 81, 0, 0, 1'b0);
    repeat (8) @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("a_midreset_vld",   32'(ifa.res_vld),     32'd0);
    chk("a_midreset_res",   ifa.res,              32'd0);
    chk("a_midreset_rdy",   32'(ifa.arg_rdy),     32'd1);
    chk("a_midreset_x_vld", 32'(ifa.isqrt_x_vld), 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    repeat (6) @(negedge clk);
    send_a(0, 1, 100, 11, 11, 1'b1);
    idle_a();

    // B: one round of four maximum arguments.
    send_b(32'hFFFF_FFFF, 32'd262140, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b_rdy_busy", 32'(ifb.arg_rdy), 32'd0);
    end
    @(negedge clk);
    chk("b_rdy_after_done", 32'(ifb.arg_rdy), 32'd1);
    idle_b();

    // C: zero argument, then a stray strobe in IDLE before isqrt(49).
    send_c(0, 0, 3);
    idle_c();
    @(posedge clk); #2;
    inj_c = 1'b1;
    @(posedge clk); #2;
    inj_c = 1'b0;
    repeat (2) @(negedge clk);
    send_c(49, 7, 3);
    idle_c();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
